// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with a registered read port, occupancy
// count, programmable almost-full/almost-empty flags, synchronous flush and
// sticky overflow/underflow error flags.
module sync_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_d,
  output logic              full,
  output logic              almost_full,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_d,
  output logic              rd_vld,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf,
  input  logic              err_clr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_CNT = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_vld_q, rd_vld_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_acc, rd_acc;

  // Flags come straight from the registered count, so they describe the
  // state left by the previous edge and both requests see the same view.
  always_comb begin
    full         = (count_q == FULL_CNT);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AFULL_CNT);
    almost_empty = (count_q <= AEMPTY_CNT);
  end

  // Next-state for pointers, read data and error flags; flush masks both
  // requests so they neither move pointers nor raise an error.
  always_comb begin
    wr_acc   = wr & ~full & ~flush;
    rd_acc   = rd & ~empty & ~flush;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    rdata_d  = rdata_q;
    rd_vld_d = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (rd_acc) begin
        rptr_d   = rptr_q + 1'b1;
        rdata_d  = mem_q[rptr_q[ADDR_W-1:0]];
        rd_vld_d = 1'b1;
      end
    end
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr & full & ~flush) begin
      ovf_d = 1'b1;
    end
    if (rd & empty & ~flush) begin
      udf_d = 1'b1;
    end
    count_d = wptr_d - rptr_d;
  end

  // Storage array has no reset; a write is only committed outside reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= wr_d;
    end
  end

  // Control and read-port registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rd_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rd_vld_q <= rd_vld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign count  = count_q;
  assign rd_d   = rdata_q;
  assign rd_vld = rd_vld_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the dual-clock pipe-stage/SM FIFO.
- Buffers DATA_W-bit words in a 2^ADDR_W-entry register file.
- Adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags.
- The read port is registered: every accepted read produces a flop-driven data word plus a one-cycle valid strobe.
- Sits between same-clock pipeline stages where no clock-domain crossing is needed.

Parameters:
DATA_W, 32, width of stored word
ADDR_W, 3, address width; DEPTH = 2^ADDR_W entries (default 8)
AFULL_TH, 6, almost_full asserted when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  synchronous, active-low reset, sampled on rising clk
flush  input  1  synchronous clear of FIFO contents (pointers/count)
wr  input  1  write request
wr_d  input  DATA_W  write data
full  output  1  count == DEPTH
almost_full  output  1  count >= AFULL_TH
rd  input  1  read request
rd_d  output  DATA_W  registered read data
rd_vld  output  1  one-cycle strobe, rd_d valid
empty  output  1  count == 0
almost_empty  output  1  count <= AEMPTY_TH
count  output  ADDR_W+1  current occupancy, 0..DEPTH
ovf  output  1  sticky: write attempted while full
udf  output  1  sticky: read attempted while empty
err_clr  input  1  clears ovf/udf

Behaviour:
- Pointers
  - wptr and rptr are ADDR_W+1 bits wide; the low ADDR_W bits address memory and the MSB is the wrap bit.
  - Pointers wrap naturally from 2^(ADDR_W+1)-1 to 0.
  - count = wptr - rptr, modulo 2^(ADDR_W+1). It is kept as a register updated alongside the pointers, not recomputed combinationally.
- Flags
  - full, empty, almost_full and almost_empty decode directly from the count register, so they reflect the state after the last edge.
- Acceptance
  - wr_acc = wr & ~full. On wr_acc: mem[wptr[ADDR_W-1:0]] <= wr_d; wptr += 1.
  - rd_acc = rd & ~empty. On rd_acc: rd_d <= mem[rptr[ADDR_W-1:0]]; rptr += 1; rd_vld <= 1.
  - Otherwise rd_vld <= 0 and rd_d holds its value.
  - Read latency is 1 cycle from rd_acc to rd_vld/rd_d.
  - There is no write-to-read bypass: a word written in cycle N is readable at the earliest in cycle N+1.
- Simultaneous wr and rd
  - Both are evaluated against the pre-edge flags.
  - Not full and not empty: both accepted, count unchanged.
  - Full: read accepted, write rejected; ovf sets and the word is lost.
  - Empty: write accepted, read rejected; udf sets and rd_vld = 0.
- Error flags
  - ovf <= 1 on wr & full; udf <= 1 on rd & empty.
  - Both are sticky until err_clr = 1 or reset.
  - If err_clr and a new error occur in the same cycle, the flag reads 1 (set wins).
- Flush
  - wptr, rptr and count go to 0 and rd_vld goes to 0.
  - wr and rd in the same cycle are ignored and do not set ovf/udf.
  - rd_d holds; memory contents are not cleared. ovf/udf are unaffected.
- Reset (rst_n = 0 at the edge, priority over everything)
  - wptr = rptr = count = 0.
  - rd_d = 0, rd_vld = 0, ovf = udf = 0.
  - Flag values after reset: empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory is not reset. A reset mid-stream discards all contents.
- Priority: rst_n > flush > normal wr/rd.
- There is no FSM beyond pointer/count state. Legal configurations require AEMPTY_TH < AFULL_TH.

Test Plan:
- Reset, then 8 writes 0x11..0x88 -> count goes 1..8; almost_full rises when count = 6; full = 1 after the 8th write; a 9th write sets ovf = 1 and count stays 8.
- 8 reads after the fill -> rd_d = 0x11..0x88 in order, rd_vld one cycle after each rd; empty = 1 after the 8th read; a 9th read sets udf = 1 and rd_vld stays 0.
- Hold count = 4 with wr & rd every cycle for 20 cycles -> count stays 4, data stays in order, pointers wrap past 15 -> 0 without a glitch on full/empty.
- Simultaneous wr & rd while full -> read returns the oldest word, write is dropped, ovf = 1, count = 7; wr & rd while empty -> count = 1, rd_vld = 0, udf = 1.
- Write 5 words, then flush together with wr = 1 -> count = 0, empty = 1, no ovf set; err_clr = 1 on the same cycle as a new ovf -> ovf reads 1.
- Drive rst_n = 0 for 1 cycle at count = 5 with rd_vld = 1 -> next cycle count = 0, rd_vld = 0, rd_d = 0, ovf = udf = 0.
